// File: rtl/uart_rx_unit_pkg.sv
// -----------------------------------------------------------------------------
// uart_rx_unit_pkg
// Shared UART definitions for the receive unit. The transmit side uses the
// same package, so the frame constants and state encodings live here.
//   UART_DATA_BITS : data bits per frame
//   IDLE_LEVEL     : line level while idle and during the stop bit
//   rx_state_e     : receive FSM state encodings
//   baud_div()     : clock cycles per oversample tick
// Optional feature macro: UART_RX_PARITY_EN (adds the PARITY state).
// -----------------------------------------------------------------------------
package uart_rx_unit_pkg;

  localparam int   UART_DATA_BITS = 8;
  localparam logic IDLE_LEVEL     = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_DATA    = 3'd2,
`ifdef UART_RX_PARITY_EN
    ST_PARITY  = 3'd3,
`endif
    ST_STOP    = 3'd4,
    ST_WAIT_HI = 3'd5
  } rx_state_e;

  // Integer division: any remainder is absorbed as a small baud error.
  function automatic int baud_div(input int clk_hz, input int baud, input int oversample);
    return clk_hz / (baud * oversample);
  endfunction

endpackage

// File: rtl/uart_rx_unit_if.sv
// -----------------------------------------------------------------------------
// uart_rx_unit_if
// Peripheral-bus side of the UART receiver.
//   rd_pop    : bus read of the data register, pops one byte
//   clr_err   : clears the sticky overrun / frame_err flags
//   rx_data   : FIFO head byte, 8'h00 when empty
//   rx_valid  : FIFO non-empty
//   rx_count  : bytes held
//   overrun   : sticky, a byte was dropped on a full FIFO
//   frame_err : sticky, stop bit (or parity) check failed
//   rx_irq    : level receive interrupt, equals rx_valid
// Modports: master = bus / CPU side, slave = receiver.
// -----------------------------------------------------------------------------
interface uart_rx_unit_if;

  logic       rd_pop;
  logic       clr_err;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [4:0] rx_count;
  logic       overrun;
  logic       frame_err;
  logic       rx_irq;

  modport master (
    output rd_pop, clr_err,
    input  rx_data, rx_valid, rx_count, overrun, frame_err, rx_irq
  );

  modport slave (
    input  rd_pop, clr_err,
    output rx_data, rx_valid, rx_count, overrun, frame_err, rx_irq
  );

endinterface

// File: rtl/uart_baud_tick.sv
// -----------------------------------------------------------------------------
// uart_baud_tick
// Free-running divider producing a one-cycle tick every DIV clocks.
//   clk   : system clock
//   reset : synchronous, active-high; counter back to 0
//   tick  : registered one-cycle pulse, period DIV clocks
// -----------------------------------------------------------------------------
module uart_baud_tick #(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  // NOTE: sequential state is assigned with <= so every flop samples the
  // pre-edge values; blocking assignments here would create ordering races.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (cnt == CW'(DIV - 1)) begin
      cnt  <= '0;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt + 1'b1;
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_rx_unit.sv
// -----------------------------------------------------------------------------
// uart_rx_unit
// UART receive front end: synchronises RX, detects and validates the start
// bit, oversamples 8N1 frames (8E1 with UART_RX_PARITY_EN defined) and queues
// received bytes in a small FIFO read from the peripheral bus.
//   clk   : system clock, all logic on posedge
//   reset : synchronous, active-high
//   RX    : asynchronous serial line, idle high
//   bus   : uart_rx_unit_if.slave (rd_pop, clr_err in; data/status/irq out)
// Optional feature macro: UART_RX_PARITY_EN (even parity bit after the data).
// -----------------------------------------------------------------------------
import uart_rx_unit_pkg::*;

module uart_rx_unit #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           RX,
  uart_rx_unit_if.slave  bus
);

  localparam int DIV = baud_div(CLK_HZ, BAUD, OVERSAMPLE);
  localparam int TW  = $clog2(OVERSAMPLE);
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int CW  = PW + 1;

  // ---------------------------------------------------------------------------
  // RX synchroniser: the FSM only ever looks at rx_sync.
  // ---------------------------------------------------------------------------
  logic rx_meta;
  logic rx_sync;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= IDLE_LEVEL;
      rx_sync <= IDLE_LEVEL;
    end else begin
      rx_meta <= RX;
      rx_sync <= rx_meta;
    end
  end

  // ---------------------------------------------------------------------------
  // Oversample tick
  // ---------------------------------------------------------------------------
  logic baud_tick;

  uart_baud_tick #(
    .DIV (DIV)
  ) u_baud_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (baud_tick)
  );

  // ---------------------------------------------------------------------------
  // Receive FSM
  // ---------------------------------------------------------------------------
  rx_state_e   state;
  logic [TW-1:0] tick_cnt;
  logic [2:0]  bit_cnt;
  logic [7:0]  shreg;
  logic        push_req;
  logic        frame_err_q;
  logic        half_bit;
  logic        full_bit;

  // START samples at the bit centre; later bits are one full bit apart.
  assign half_bit = baud_tick && (tick_cnt == TW'(OVERSAMPLE / 2 - 1));
  assign full_bit = baud_tick && (tick_cnt == TW'(OVERSAMPLE - 1));

`ifdef UART_RX_PARITY_EN
  logic parity_err;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      tick_cnt    <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
      push_req    <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err  <= 1'b0;
`endif
    end else begin
      push_req <= 1'b0;
      // Clear first; any set later in this block overrides it.
      if (bus.clr_err) frame_err_q <= 1'b0;

      if (baud_tick && state != ST_IDLE && state != ST_WAIT_HI)
        tick_cnt <= tick_cnt + 1'b1;

      case (state)
        ST_IDLE: begin
          if (rx_sync != IDLE_LEVEL) begin
            state    <= ST_START;
            tick_cnt <= '0;
          end
        end

        ST_START: begin
          if (half_bit) begin
            tick_cnt <= '0;
            bit_cnt  <= '0;
            // A line already back high at mid-start was a glitch.
            state    <= (rx_sync == IDLE_LEVEL) ? ST_IDLE : ST_DATA;
          end
        end

        ST_DATA: begin
          if (full_bit) begin
            tick_cnt <= '0;
            shreg    <= {rx_sync, shreg[7:1]};   // LSB first
            bit_cnt  <= bit_cnt + 1'b1;
            if (bit_cnt == 3'(UART_DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
              state <= ST_PARITY;
`else
              state <= ST_STOP;
`endif
            end
          end
        end

`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (full_bit) begin
            tick_cnt   <= '0;
            // Even parity: data bits plus parity bit must XOR to 0.
            parity_err <= ^{shreg, rx_sync};
            state      <= ST_STOP;
          end
        end
`endif

        ST_STOP: begin
          if (full_bit) begin
            tick_cnt <= '0;
            if (rx_sync != IDLE_LEVEL) begin
              frame_err_q <= 1'b1;
              state       <= ST_WAIT_HI;
            end else begin
              state <= ST_IDLE;
`ifdef UART_RX_PARITY_EN
              if (parity_err) frame_err_q <= 1'b1;
              else            push_req    <= 1'b1;
`else
              push_req <= 1'b1;
`endif
            end
          end
        end

        // Hold off until the line idles so a break cannot re-trigger START.
        ST_WAIT_HI: begin
          if (rx_sync == IDLE_LEVEL) state <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Receive FIFO. shreg is stable on the push cycle: the FSM is in IDLE and
  // no new data bit can be shifted in for at least half a bit.
  // ---------------------------------------------------------------------------
  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          overrun_q;
  logic          fifo_full;
  logic          do_pop;
  logic          do_push;
  logic          drop;

  assign fifo_full = (count == CW'(FIFO_DEPTH));
  assign do_pop    = bus.rd_pop && (count != '0);
  // A pop on the same edge frees the slot, so a full FIFO still accepts.
  assign do_push   = push_req && (!fifo_full || do_pop);
  assign drop      = push_req && fifo_full && !do_pop;

  // NOTE: the storage array has no reset; rx_data is forced to zero while the
  // FIFO is empty, so stale contents are never visible.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= shreg;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop)             overrun_q <= 1'b1;
      else if (bus.clr_err) overrun_q <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Bus outputs
  // ---------------------------------------------------------------------------
  assign bus.rx_valid  = (count != '0);
  assign bus.rx_data   = bus.rx_valid ? mem[rd_ptr] : 8'h00;
  assign bus.rx_count  = 5'(count);
  assign bus.overrun   = overrun_q;
  assign bus.frame_err = frame_err_q;
  assign bus.rx_irq    = bus.rx_valid;

endmodule
